// File: rtl/pdm_pkg.sv
// Shared definitions for the PCM capture path: default sample width and
// the output-stage state type of the sample FIFO.
package pdm_pkg;

    localparam int PCM_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } out_state_t;

endpackage

// File: rtl/pcm_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// one-cycle read latency, no reset on storage or read data.
module pcm_sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO: RAM-backed buffer with a registered output stage,
// sticky overflow flag and saturating drop counter.
//
// state | meaning
// EMPTY | output register idle, no sample presented
// FETCH | RAM read in flight, data lands in m_data at next edge
// HOLD  | m_data presented with m_valid=1, waiting for m_ready
module pcm_sample_fifo
    import pdm_pkg::*;
#(
    parameter int DATA_WIDTH  = PCM_WIDTH,
    parameter int DEPTH       = 256,
    parameter int ALMOST_FULL = 192
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_WIDTH-1:0]    pcm_in,
    input  logic                     pcm_valid,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [15:0]              drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    out_state_t            state, state_next;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  wr_en, rd_en, drop;
    logic                  has_data;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign has_data = (level != '0);
    // Full is judged on the pre-edge level, so a same-cycle read never rescues a write.
    assign wr_en    = pcm_valid && (level < LW'(DEPTH));
    assign drop     = pcm_valid && !wr_en;

    pcm_sdp_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (pcm_in),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            EMPTY: begin
                if (has_data) begin
                    rd_en      = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = HOLD;
            HOLD: begin
                if (m_ready) begin
                    if (has_data) begin
                        rd_en      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            m_data <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) m_data <= ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    assign m_valid     = (state == HOLD);
    assign almost_full = (level >= LW'(ALMOST_FULL));

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Self-checking bench for pcm_sample_fifo: queue-based reference model,
// a vector table for single-sample latency, directed corner sequences and
// a randomized stream.
module tb_pcm_sample_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int AF    = 192;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pcm_in;
    logic          pcm_valid;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          almost_full;
    logic          overflow;
    logic          clear_overflow;
    logic [15:0]   drop_count;

    pcm_sample_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .ALMOST_FULL (AF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pcm_in         (pcm_in),
        .pcm_valid      (pcm_valid),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .level          (level),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: samples in storage, output stage phase
    // (0 idle, 1 fetch in flight, 2 presenting), fetched/presented values.
    logic [DW-1:0] mq [$];
    int            ph;
    logic [DW-1:0] mfetch, mout;
    bit            movf;
    int            mdrop;
    logic [DW-1:0] delivered [$];

    typedef struct {
        logic          pv;
        logic [DW-1:0] din;
        logic          rdy;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        int            exp_lvl;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ph     = 0;
        mfetch = '0;
        mout   = '0;
        movf   = 0;
        mdrop  = 0;
    endtask

    task automatic tick();
        bit wr, rd, drp;
        int nph;
        if (m_valid && m_ready) delivered.push_back(m_data);
        wr  = pcm_valid && (mq.size() < DEPTH);
        drp = pcm_valid && !wr;
        rd  = (mq.size() > 0) && (ph == 0 || (ph == 2 && m_ready));
        nph = ph;
        case (ph)
            0: if (mq.size() > 0) nph = 1;
            1: begin nph = 2; mout = mfetch; end
            2: if (m_ready) nph = (mq.size() > 0) ? 1 : 0;
            default: nph = 0;
        endcase
        if (rd) mfetch = mq.pop_front();
        if (wr) mq.push_back(pcm_in);
        if (clear_overflow) begin
            movf  = 0;
            mdrop = 0;
        end else if (drp) begin
            movf = 1;
            if (mdrop < 65535) mdrop++;
        end
        ph = nph;
        @(posedge clk);
        #1;
        check("m_valid", 32'(m_valid), 32'(ph == 2));
        check("m_data", 32'(m_data), 32'(mout));
        check("level", 32'(level), 32'(mq.size()));
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
        check("overflow", 32'(overflow), 32'(movf));
        check("drop_count", 32'(drop_count), 32'(mdrop));
    endtask

    task automatic do_reset();
        pcm_valid      = 1'b0;
        pcm_in         = '0;
        clear_overflow = 1'b0;
        rst_n          = 1'b0;
        #1;
        check("rst m_valid", 32'(m_valid), 32'd0);
        check("rst level", 32'(level), 32'd0);
        check("rst m_data", 32'(m_data), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst drop_count", 32'(drop_count), 32'd0);
        check("rst almost_full", 32'(almost_full), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_sample(input logic [DW-1:0] d);
        pcm_valid = 1'b1;
        pcm_in    = d;
        tick();
        pcm_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vec_t tbl [4];
        int   budget;
        int   gap;
        int   sent;

        rst_n          = 1'b1;
        pcm_valid      = 1'b0;
        pcm_in         = '0;
        m_ready        = 1'b0;
        clear_overflow = 1'b0;
        model_reset();
        #2;

        // Single sample, m_ready=1: valid after the second edge, then drains.
        tbl[0] = '{1'b1, 16'h8001, 1'b1, 1'b0, 16'h0000, 1};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 0};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8001, 0};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8001, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pcm_valid = tbl[i].pv;
            pcm_in    = tbl[i].din;
            m_ready   = tbl[i].rdy;
            tick();
            check("vec m_valid", 32'(m_valid), 32'(tbl[i].exp_v));
            check("vec m_data", 32'(m_data), 32'(tbl[i].exp_d));
            check("vec level", 32'(level), 32'(tbl[i].exp_lvl));
        end
        pcm_valid = 1'b0;

        // Backpressure: the first sample moves straight into the output register.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            write_sample(16'(i));
            idle(2);
        end
        check("bp level held", 32'(level), 32'd9);
        check("bp head presented", 32'(m_data), 32'd0);
        delivered.delete();
        m_ready = 1'b1;
        budget  = 0;
        while (delivered.size() < 10 && budget < 200) begin
            tick();
            budget++;
        end
        check("bp delivered count", 32'(delivered.size()), 32'd10);
        for (int i = 0; i < 10 && i < delivered.size(); i++)
            check("bp order", 32'(delivered[i]), 32'(i));
        idle(3);
        check("bp drained level", 32'(level), 32'd0);

        // Overflow with m_ready=0: 1 sample held in output, 256 stored, 3 dropped.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            write_sample(16'(i));
            if (i == 191) check("af below threshold", 32'(almost_full), 32'd0);
            if (i == 192) check("af at threshold", 32'(almost_full), 32'd1);
        end
        check("ovf level", 32'(level), 32'd256);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf drops", 32'(drop_count), 32'd3);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check("clr flag", 32'(overflow), 32'd0);
        check("clr drops", 32'(drop_count), 32'd0);

        // Write at full while HOLD releases: dropped, level still decrements.
        pcm_valid = 1'b1;
        pcm_in    = 16'hABCD;
        m_ready   = 1'b1;
        tick();
        pcm_valid = 1'b0;
        m_ready   = 1'b0;
        check("full+release level", 32'(level), 32'd255);
        check("full+release drops", 32'(drop_count), 32'd1);
        write_sample(16'h5555);
        check("refill level", 32'(level), 32'd256);
        clear_overflow = 1'b1;
        write_sample(16'h6666);
        clear_overflow = 1'b0;
        check("clear vs drop count", 32'(drop_count), 32'd0);
        check("clear vs drop flag", 32'(overflow), 32'd0);
        check("clear vs drop level", 32'(level), 32'd256);

        // Reset mid-stream, then a lone sample with 2-cycle latency.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 50; i++) write_sample(16'(16'h100 + i));
        check("pre-rst valid", 32'(m_valid), 32'd1);
        do_reset();
        delivered.delete();
        m_ready = 1'b1;
        write_sample(16'h1234);
        check("post-rst lat0", 32'(m_valid), 32'd0);
        tick();
        check("post-rst lat1", 32'(m_valid), 32'd0);
        tick();
        check("post-rst lat2 valid", 32'(m_valid), 32'd1);
        check("post-rst lat2 data", 32'(m_data), 32'h1234);
        idle(4);
        check("post-rst count", 32'(delivered.size()), 32'd1);
        if (delivered.size() > 0) check("post-rst sample", 32'(delivered[0]), 32'h1234);

        // Randomized stream with random m_ready: ordering, no drops, bounded level.
        do_reset();
        delivered.delete();
        sent   = 0;
        gap    = 0;
        budget = 0;
        while (delivered.size() < 1000 && budget < 20000) begin
            if (sent < 1000 && gap == 0) begin
                pcm_valid = 1'b1;
                pcm_in    = 16'(sent);
                sent++;
                gap = $urandom_range(2, 5);
            end else begin
                pcm_valid = 1'b0;
                if (gap > 0) gap--;
            end
            m_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        pcm_valid = 1'b0;
        check("rand delivered count", 32'(delivered.size()), 32'd1000);
        for (int i = 0; i < delivered.size(); i++)
            check("rand order", 32'(delivered[i]), 32'(i));
        check("rand drops", 32'(drop_count), 32'd0);
        check("rand overflow", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
